// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues paired fetches, queues the returned words in order,
// and presents up to two instructions per cycle to decode. A redirect flushes everything.
module if_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [63:0]                io_if_mem_instAddr,
    input  logic [31:0]                io_mem_id_inst_0,
    input  logic [31:0]                io_mem_id_inst_1,
    input  logic                       io_redirect_valid,
    input  logic [63:0]                io_redirect_pc,
    output logic                       io_id_valid_0,
    output logic                       io_id_valid_1,
    output logic [31:0]                io_id_inst_0,
    output logic [31:0]                io_id_inst_1,
    output logic [63:0]                io_id_pc_0,
    output logic [63:0]                io_id_pc_1,
    input  logic                       io_id_ready_0,
    input  logic                       io_id_ready_1,
    output logic [$clog2(DEPTH):0]     io_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   ISSUE_LIMIT = (CW + 1)'(DEPTH - 2);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW-1:0] PTR_TWO     = AW'(2);

    logic [63:0]   pc;
    logic [63:0]   inflight_pc;
    logic          inflight;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [63:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          enq;
    logic          deq0;
    logic          deq1;
    logic [AW-1:0] head_1;
    logic [CW-1:0] count_next;

    // Reserve room for the in-flight pair before issuing another; uses pre-dequeue count.
    assign occupancy = {1'b0, count} + (CW + 1)'({inflight, 1'b0});
    assign issue     = !io_redirect_valid && (occupancy <= ISSUE_LIMIT);
    assign enq       = inflight && !io_redirect_valid;

    // Handshake: a slot transfers when its valid and ready are both high in the same cycle;
    // slot 1 may only transfer together with slot 0, and valids are suppressed during redirect.
    assign io_id_valid_0 = !io_redirect_valid && (count >= CW'(1));
    assign io_id_valid_1 = !io_redirect_valid && (count >= CW'(2));
    assign deq0          = io_id_valid_0 && io_id_ready_0;
    assign deq1          = deq0 && io_id_valid_1 && io_id_ready_1;

    assign head_1       = head + PTR_ONE;
    assign io_id_pc_0   = q_pc[head];
    assign io_id_inst_0 = q_inst[head];
    assign io_id_pc_1   = q_pc[head_1];
    assign io_id_inst_1 = q_inst[head_1];

    assign count_next         = count + CW'({enq, 1'b0}) - CW'(deq0) - CW'(deq1);
    assign io_count           = count;
    assign io_if_mem_instAddr = pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (io_redirect_valid) begin
            // Dropping inflight discards the memory response that arrives next cycle.
            pc       <= io_redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 64'd8;
            end
            if (enq) begin
                tail <= tail + PTR_TWO;
            end
            head  <= head + AW'(deq0) + AW'(deq1);
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (enq && reset) begin
            q_pc[tail]            <= inflight_pc;
            q_inst[tail]          <= io_mem_id_inst_0;
            q_pc[tail + PTR_ONE]   <= inflight_pc + 64'd4;
            q_inst[tail + PTR_ONE] <= io_mem_id_inst_1;
        end
    end
endmodule
